// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dual-issue allocation, four-lane CDB snoop,
// and up to two oldest-first commits per cycle on registered outputs.
module reorder_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             alloc_valid_A,
    input  logic [7:0]       alloc_tag_A,
    input  logic [4:0]       alloc_rd_A,
    input  logic             alloc_valid_B,
    input  logic [7:0]       alloc_tag_B,
    input  logic [4:0]       alloc_rd_B,
    output logic             alloc_ready,
    input  logic [31:0]      CDB_tag_serialized,
    input  logic [127:0]     CDB_data_serialized,
    output logic             commit_valid_A,
    output logic             commit_valid_B,
    output logic [4:0]       commit_rd_A,
    output logic [4:0]       commit_rd_B,
    output logic [7:0]       commit_tag_A,
    output logic [7:0]       commit_tag_B,
    output logic [31:0]      commit_data_A,
    output logic [31:0]      commit_data_B,
    output logic [PTR_W:0]   count,
    output logic             overflow_err
);

    localparam int LANES = 4;
    localparam logic [PTR_W:0] READY_MAX = (PTR_W + 1)'(DEPTH - 2);

    logic             busy_reg [DEPTH];
    logic             done_reg [DEPTH];
    logic [7:0]       tag_reg  [DEPTH];
    logic [4:0]       rd_reg   [DEPTH];
    logic [31:0]      data_reg [DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W:0]   count_reg;

    logic [7:0]       lane_tag   [LANES];
    logic [31:0]      lane_data  [LANES];
    logic             snoop_hit  [DEPTH];
    logic [31:0]      snoop_data [DEPTH];

    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] slot_b;
    logic             commit_a;
    logic             commit_b;
    logic             alloc_a;
    logic             alloc_b;
    logic [1:0]       n_alloc;
    logic [1:0]       n_commit;

    genvar gi, gk;

    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_tag[gi]  = CDB_tag_serialized[8*gi +: 8];
            assign lane_data[gi] = CDB_data_serialized[32*gi +: 32];
        end
    endgenerate

    // Only pending entries snoop; a slot being allocated this cycle is not busy yet.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_snoop
            logic [LANES-1:0] lane_match;
            for (gk = 0; gk < LANES; gk++) begin : g_match
                assign lane_match[gk] = lane_tag[gk][7] && (lane_tag[gk] == tag_reg[gi]);
            end
            assign snoop_hit[gi]  = busy_reg[gi] && !done_reg[gi] && (|lane_match);
            assign snoop_data[gi] = lane_match[0] ? lane_data[0] :
                                    lane_match[1] ? lane_data[1] :
                                    lane_match[2] ? lane_data[2] : lane_data[3];
        end
    endgenerate

    assign head_next   = head_reg + PTR_W'(1);
    assign commit_a    = busy_reg[head_reg] && done_reg[head_reg];
    assign commit_b    = commit_a && busy_reg[head_next] && done_reg[head_next];
    assign alloc_ready = (count_reg <= READY_MAX);
    assign alloc_a     = alloc_ready && alloc_valid_A;
    assign alloc_b     = alloc_ready && alloc_valid_B;
    assign slot_b      = alloc_a ? tail_reg + PTR_W'(1) : tail_reg;
    assign n_alloc     = {1'b0, alloc_a} + {1'b0, alloc_b};
    assign n_commit    = {1'b0, commit_a} + {1'b0, commit_b};
    assign count       = count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_reg[i] <= 1'b0;
                done_reg[i] <= 1'b0;
                tag_reg[i]  <= '0;
                rd_reg[i]   <= '0;
                data_reg[i] <= '0;
            end
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            commit_valid_A <= 1'b0;
            commit_valid_B <= 1'b0;
            commit_rd_A    <= '0;
            commit_rd_B    <= '0;
            commit_tag_A   <= '0;
            commit_tag_B   <= '0;
            commit_data_A  <= '0;
            commit_data_B  <= '0;
            overflow_err   <= 1'b0;
        end else begin
            if ((alloc_valid_A || alloc_valid_B) && !alloc_ready) begin
                overflow_err <= 1'b1;
            end
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    busy_reg[i] <= 1'b0;
                    done_reg[i] <= 1'b0;
                end
                head_reg       <= '0;
                tail_reg       <= '0;
                count_reg      <= '0;
                commit_valid_A <= 1'b0;
                commit_valid_B <= 1'b0;
            end else begin
                // Snooped, committed and allocated slots are always disjoint.
                for (int i = 0; i < DEPTH; i++) begin
                    if (snoop_hit[i]) begin
                        done_reg[i] <= 1'b1;
                        data_reg[i] <= snoop_data[i];
                    end
                end
                if (commit_a) begin
                    busy_reg[head_reg] <= 1'b0;
                    done_reg[head_reg] <= 1'b0;
                end
                if (commit_b) begin
                    busy_reg[head_next] <= 1'b0;
                    done_reg[head_next] <= 1'b0;
                end
                if (alloc_a) begin
                    busy_reg[tail_reg] <= 1'b1;
                    done_reg[tail_reg] <= 1'b0;
                    tag_reg[tail_reg]  <= alloc_tag_A;
                    rd_reg[tail_reg]   <= alloc_rd_A;
                end
                if (alloc_b) begin
                    busy_reg[slot_b] <= 1'b1;
                    done_reg[slot_b] <= 1'b0;
                    tag_reg[slot_b]  <= alloc_tag_B;
                    rd_reg[slot_b]   <= alloc_rd_B;
                end
                head_reg  <= head_reg + PTR_W'(n_commit);
                tail_reg  <= tail_reg + PTR_W'(n_alloc);
                count_reg <= count_reg + (PTR_W + 1)'(n_alloc) - (PTR_W + 1)'(n_commit);

                commit_valid_A <= commit_a;
                commit_valid_B <= commit_b;
                if (commit_a) begin
                    commit_rd_A   <= rd_reg[head_reg];
                    commit_tag_A  <= tag_reg[head_reg];
                    commit_data_A <= data_reg[head_reg];
                end
                if (commit_b) begin
                    commit_rd_B   <= rd_reg[head_next];
                    commit_tag_B  <= tag_reg[head_next];
                    commit_data_B <= data_reg[head_next];
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: expected commits are queued at allocation
// and checked in order by a negedge monitor.
module tb_reorder_buffer;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic           clk;
    logic           reset;
    logic           flush;
    logic           alloc_valid_A;
    logic [7:0]     alloc_tag_A;
    logic [4:0]     alloc_rd_A;
    logic           alloc_valid_B;
    logic [7:0]     alloc_tag_B;
    logic [4:0]     alloc_rd_B;
    logic           alloc_ready;
    logic [31:0]    CDB_tag_serialized;
    logic [127:0]   CDB_data_serialized;
    logic           commit_valid_A;
    logic           commit_valid_B;
    logic [4:0]     commit_rd_A;
    logic [4:0]     commit_rd_B;
    logic [7:0]     commit_tag_A;
    logic [7:0]     commit_tag_B;
    logic [31:0]    commit_data_A;
    logic [31:0]    commit_data_B;
    logic [PTR_W:0] count;
    logic           overflow_err;

    reorder_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .flush               (flush),
        .alloc_valid_A       (alloc_valid_A),
        .alloc_tag_A         (alloc_tag_A),
        .alloc_rd_A          (alloc_rd_A),
        .alloc_valid_B       (alloc_valid_B),
        .alloc_tag_B         (alloc_tag_B),
        .alloc_rd_B          (alloc_rd_B),
        .alloc_ready         (alloc_ready),
        .CDB_tag_serialized  (CDB_tag_serialized),
        .CDB_data_serialized (CDB_data_serialized),
        .commit_valid_A      (commit_valid_A),
        .commit_valid_B      (commit_valid_B),
        .commit_rd_A         (commit_rd_A),
        .commit_rd_B         (commit_rd_B),
        .commit_tag_A        (commit_tag_A),
        .commit_tag_B        (commit_tag_B),
        .commit_data_A       (commit_data_A),
        .commit_data_B       (commit_data_B),
        .count               (count),
        .overflow_err        (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [7:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_commit = 0;
    int   base;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic sb_check(input string name, input logic [4:0] rd, input logic [7:0] tag,
                            input logic [31:0] data);
        exp_t got;
        exp_t e;
        got = {rd, tag, data};
        n_commit++;
        n_assert++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s: observed unexpected commit rd=%0d tag=%0h data=%0h expected none",
                   name, rd, tag, data);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_assert++;
            assert (got === e) else begin
                n_fail++;
                $error("FAIL %s: observed rd=%0d tag=%0h data=%0h expected rd=%0d tag=%0h data=%0h",
                       name, got.rd, got.tag, got.data, e.rd, e.tag, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (commit_valid_B === 1'b1) chk("b_without_a", 32'(commit_valid_A), 32'd1);
            if (commit_valid_A === 1'b1) sb_check("commit_A", commit_rd_A, commit_tag_A, commit_data_A);
            if (commit_valid_B === 1'b1) sb_check("commit_B", commit_rd_B, commit_tag_B, commit_data_B);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid_A       = 1'b0;
        alloc_tag_A         = '0;
        alloc_rd_A          = '0;
        alloc_valid_B       = 1'b0;
        alloc_tag_B         = '0;
        alloc_rd_B          = '0;
        CDB_tag_serialized  = '0;
        CDB_data_serialized = '0;
    endtask

    task automatic alloc(input logic va, input logic [7:0] ta, input logic [4:0] ra,
                         input logic vb, input logic [7:0] tb, input logic [4:0] rb);
        alloc_valid_A = va;
        alloc_tag_A   = ta;
        alloc_rd_A    = ra;
        alloc_valid_B = vb;
        alloc_tag_B   = tb;
        alloc_rd_B    = rb;
    endtask

    task automatic lane(input int k, input logic [7:0] t, input logic [31:0] d);
        CDB_tag_serialized[8*k +: 8]   = t;
        CDB_data_serialized[32*k +: 32] = d;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(alloc_ready), 32'd1);
        chk("rst_cv_a", 32'(commit_valid_A), 32'd0);
        chk("rst_cv_b", 32'(commit_valid_B), 32'd0);
        chk("rst_ovf", 32'(overflow_err), 32'd0);
        chk("rst_data_a", commit_data_A, 32'd0);
        reset = 1'b0;

        // Out-of-order completion, in-order dual retirement
        alloc(1'b1, 8'hA1, 5'd3, 1'b1, 8'hC2, 5'd5);
        sb.push_back({5'd3, 8'hA1, 32'h11});
        sb.push_back({5'd5, 8'hC2, 32'h22});
        tick(); idle();
        chk("ooo_count", 32'(count), 32'd2);
        lane(2, 8'hC2, 32'h22);
        tick(); idle();
        chk("ooo_hold1", 32'(commit_valid_A), 32'd0);
        lane(0, 8'hA1, 32'h11);
        tick(); idle();
        chk("ooo_hold2", 32'(commit_valid_A), 32'd0);
        tick();
        chk("ooo_cv_a", 32'(commit_valid_A), 32'd1);
        chk("ooo_cv_b", 32'(commit_valid_B), 32'd1);
        chk("ooo_rd_a", 32'(commit_rd_A), 32'd3);
        chk("ooo_data_a", commit_data_A, 32'h11);
        chk("ooo_rd_b", 32'(commit_rd_B), 32'd5);
        chk("ooo_data_b", commit_data_B, 32'h22);
        chk("ooo_count0", 32'(count), 32'd0);

        // Fill, overflow, single commit from a full buffer
        for (int p = 0; p < 4; p++) begin
            alloc(1'b1, 8'(8'h80 + 2*p), 5'(2*p), 1'b1, 8'(8'h81 + 2*p), 5'(2*p + 1));
            if (p == 0) sb.push_back({5'd0, 8'h80, 32'h100});
            tick(); idle();
            if (p == 2) begin
                chk("fill_count6", 32'(count), 32'd6);
                chk("fill_ready6", 32'(alloc_ready), 32'd1);
            end
        end
        chk("full_count", 32'(count), 32'd8);
        chk("full_ready", 32'(alloc_ready), 32'd0);
        alloc(1'b1, 8'h90, 5'd10, 1'b1, 8'h91, 5'd11);
        tick(); idle();
        chk("ovf_flag", 32'(overflow_err), 32'd1);
        chk("ovf_count", 32'(count), 32'd8);
        lane(0, 8'h80, 32'h100);
        tick(); idle();
        chk("full_nocommit", 32'(commit_valid_A), 32'd0);
        tick();
        chk("full_cv_a", 32'(commit_valid_A), 32'd1);
        chk("full_cv_b", 32'(commit_valid_B), 32'd0);
        chk("full_count7", 32'(count), 32'd7);
        chk("full_ready7", 32'(alloc_ready), 32'd0);

        // Asynchronous reset in the middle of a cycle
        #3 reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_ready", 32'(alloc_ready), 32'd1);
        chk("arst_cv_a", 32'(commit_valid_A), 32'd0);
        chk("arst_cv_b", 32'(commit_valid_B), 32'd0);
        chk("arst_ovf", 32'(overflow_err), 32'd0);
        sb.delete();
        #2 reset = 1'b0;
        tick();
        lane(0, 8'h81, 32'h81);
        tick(); idle();
        tick();
        tick();
        chk("arst_discard", 32'(commit_valid_A), 32'd0);
        chk("arst_count0", 32'(count), 32'd0);

        // Pointer wrap: 20 single allocations, each completed one cycle later
        base = n_commit;
        for (int i = 0; i <= 20; i++) begin
            idle();
            if (i < 20) begin
                alloc(1'b1, 8'(8'h80 + i), 5'(i), 1'b0, 8'h00, 5'd0);
                sb.push_back({5'(i), 8'(8'h80 + i), 32'(i)});
            end
            if (i > 0) lane((i - 1) % 4, 8'(8'h80 + i - 1), 32'(i - 1));
            tick();
            chk("wrap_count_gt2", 32'(count > 4'd2), 32'd0);
        end
        idle();
        repeat (3) tick();
        chk("wrap_commits", 32'(n_commit - base), 32'd20);
        chk("wrap_count0", 32'(count), 32'd0);

        // Lane filtering: lane-valid bit and lowest-lane priority
        alloc(1'b1, 8'hA1, 5'd7, 1'b1, 8'h21, 5'd6);
        sb.push_back({5'd7, 8'hA1, 32'h1});
        tick(); idle();
        chk("filt_count", 32'(count), 32'd2);
        lane(0, 8'h21, 32'hBAD);
        tick(); idle();
        lane(0, 8'h21, 32'hBAD);
        lane(1, 8'hA1, 32'h1);
        lane(3, 8'hA1, 32'h2);
        tick(); idle();
        tick();
        chk("filt_cv_a", 32'(commit_valid_A), 32'd1);
        chk("filt_data_a", commit_data_A, 32'h1);
        chk("filt_cv_b", 32'(commit_valid_B), 32'd0);
        chk("filt_count1", 32'(count), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("filt_flush_count", 32'(count), 32'd0);

        // Entry allocated in the same cycle as a matching broadcast ignores it
        alloc(1'b0, 8'h00, 5'd0, 1'b1, 8'h85, 5'd9);
        lane(2, 8'h85, 32'hBAD);
        tick(); idle();
        chk("same_count", 32'(count), 32'd1);
        tick();
        tick();
        chk("same_nocapture", 32'(commit_valid_A), 32'd0);
        sb.push_back({5'd9, 8'h85, 32'h55});
        lane(1, 8'h85, 32'h55);
        tick(); idle();
        tick();
        chk("same_cv_a", 32'(commit_valid_A), 32'd1);
        chk("same_rd_a", 32'(commit_rd_A), 32'd9);
        chk("same_data_a", commit_data_A, 32'h55);
        chk("same_count0", 32'(count), 32'd0);

        // Flush while entries complete and the head is about to retire
        alloc(1'b1, 8'h81, 5'd1, 1'b1, 8'h82, 5'd2);
        tick(); idle();
        alloc(1'b1, 8'h83, 5'd3, 1'b0, 8'h00, 5'd0);
        tick(); idle();
        chk("flush_count3", 32'(count), 32'd3);
        lane(0, 8'h81, 32'h1);
        tick(); idle();
        flush = 1'b1;
        lane(0, 8'h81, 32'h1);
        lane(1, 8'h82, 32'h2);
        lane(2, 8'h83, 32'h3);
        tick(); idle();
        flush = 1'b0;
        chk("flush_count0", 32'(count), 32'd0);
        chk("flush_cv_a", 32'(commit_valid_A), 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("flush_quiet_a", 32'(commit_valid_A), 32'd0);
            chk("flush_quiet_b", 32'(commit_valid_B), 32'd0);
        end

        for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
